// File: rtl/alu_issue.sv
// Issue FSM for an external registered ALU: accepts one command, drives alu_*, captures the result.
// Optional build macro ALU_ISSUE_CHAIN_EN adds a last-result register usable as operand A.
module alu_issue #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [2:0]       alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_c,
  output logic [2:0]       res_f,
  output logic             res_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  state_t     state;
  alu_req_t   req;
  logic       accept;
  logic       supported;

  assign accept    = cmd_valid && cmd_ready;
  assign supported = (cmd_op < 3'd6);

`ifdef ALU_ISSUE_CHAIN_EN
  logic [WIDTH-1:0] last_res;
  assign req.a = cmd_chain ? last_res : cmd_a;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign req.a = cmd_a;
`endif
  assign req.op = cmd_op;
  assign req.b  = cmd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_c     <= '0;
      res_f     <= '0;
      res_err   <= 1'b0;
`ifdef ALU_ISSUE_CHAIN_EN
      last_res  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            if (supported) begin
              alu_op <= req.op;
              alu_a  <= req.a;
              alu_b  <= req.b;
              state  <= ISSUE;
            end else begin
              // Unsupported opcode skips the ALU entirely and reports an error result.
              res_c     <= '0;
              res_f     <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          res_c     <= alu_c;
          res_f     <= alu_f;
          res_err   <= 1'b0;
          res_valid <= 1'b1;
`ifdef ALU_ISSUE_CHAIN_EN
          last_res  <= alu_c;
`endif
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural registered ALU driving alu_c/alu_f.
module tb_alu_issue;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_chain;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_c;
  logic [2:0]   alu_f;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_c;
  logic [2:0]   res_f;
  logic         res_err;

  int checks = 0;
  int errors = 0;

  alu_issue #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_f(res_f), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Registered ALU: samples alu_* every rising edge; flags {carry/borrow, overflow, zero}.
  always @(posedge clk) begin
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         cy, ov;
    s = '0; cy = 1'b0; ov = 1'b0;
    case (alu_op)
      3'd0: begin s = {1'b0, alu_a} + {1'b0, alu_b}; r = s[W-1:0]; cy = s[W];
                  ov = (alu_a[W-1] == alu_b[W-1]) && (r[W-1] != alu_a[W-1]); end
      3'd1: begin r = alu_a - alu_b; cy = (alu_a < alu_b);
                  ov = (alu_a[W-1] != alu_b[W-1]) && (r[W-1] != alu_a[W-1]); end
      3'd2: r = alu_a & alu_b;
      3'd3: r = alu_a | alu_b;
      3'd4: r = ~alu_a;
      3'd5: r = alu_a ^ alu_b;
      default: r = '0;
    endcase
    alu_c <= r;
    alu_f <= {cy, ov, (r == '0)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for one edge; caller guarantees cmd_ready is 1.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic chain);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    step();
    cmd_valid = 1'b0; cmd_chain = 1'b0;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; res_ready = 1'b0;
    #3;
    checks++;
    if ({cmd_ready, res_valid, res_err, res_c, res_f, alu_op, alu_a, alu_b} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, 3'b0, 3'b0, {W{1'b0}}, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b vld=%b err=%b c=%0d f=%b op=%0d a=%0d b=%0d exp rdy=1 rest 0",
               cmd_ready, res_valid, res_err, res_c, res_f, alu_op, alu_a, alu_b);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_idle_res_ready();
    res_ready = 1'b1;
    step(); step();
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL idle_res_ready vld/rdy got %b%b exp 01", res_valid, cmd_ready);
    end
  endtask

  task automatic test_add_overflow();
    send(3'd0, 6'd63, 6'd1, 1'b0);
    checks++;
    if ({alu_op, alu_a, alu_b} !== {3'd0, 6'd63, 6'd1}) begin
      errors++; $display("FAIL add_issue op=%0d a=%0d b=%0d exp 0 63 1", alu_op, alu_a, alu_b);
    end
    checks++;
    if ({res_valid, cmd_ready} !== 2'b00) begin
      errors++; $display("FAIL add_lat1 vld/rdy got %b%b exp 00", res_valid, cmd_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL add_lat2 vld got %b exp 0", res_valid); end
    step();
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL add_lat3 vld got %b exp 1", res_valid); end
    checks++;
    if ({res_c, res_f, res_err} !== {6'd0, 3'b101, 1'b0}) begin
      errors++; $display("FAIL add_ovf_res c=%0d f=%b err=%b exp 0 101 0", res_c, res_f, res_err);
    end
    release_res();
  endtask

  task automatic test_sub_and_ovf();
    send(3'd1, 6'd3, 6'd5, 1'b0);
    step(); step();
    checks++;
    if ({res_valid, res_c, res_f, res_err} !== {1'b1, 6'd62, 3'b100, 1'b0}) begin
      errors++; $display("FAIL sub_res vld=%b c=%0d f=%b err=%b exp 1 62 100 0", res_valid, res_c, res_f, res_err);
    end
    release_res();
    send(3'd0, 6'd31, 6'd1, 1'b0);
    step(); step();
    checks++;
    if ({res_valid, res_c, res_f, res_err} !== {1'b1, 6'd32, 3'b010, 1'b0}) begin
      errors++; $display("FAIL add31_res vld=%b c=%0d f=%b err=%b exp 1 32 010 0", res_valid, res_c, res_f, res_err);
    end
    release_res();
    send(3'd5, 6'd42, 6'd15, 1'b0);
    step(); step();
    checks++;
    if ({res_c, res_f} !== {6'd37, 3'b000}) begin
      errors++; $display("FAIL xor_res c=%0d f=%b exp 37 000", res_c, res_f);
    end
    release_res();
  endtask

  task automatic test_unsupported();
    // alu_* still hold the previous XOR command (42 ^ 15)
    send(3'd7, 6'd9, 6'd9, 1'b0);
    checks++;
    if ({res_valid, res_c, res_f, res_err} !== {1'b1, 6'd0, 3'b000, 1'b1}) begin
      errors++; $display("FAIL bad_op_res vld=%b c=%0d f=%b err=%b exp 1 0 000 1", res_valid, res_c, res_f, res_err);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== {3'd5, 6'd42, 6'd15}) begin
      errors++; $display("FAIL bad_op_alu op=%0d a=%0d b=%0d exp 5 42 15", alu_op, alu_a, alu_b);
    end
    release_res();
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL bad_op_release vld/rdy got %b%b exp 01", res_valid, cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send(3'd1, 6'd3, 6'd5, 1'b0);
    step(); step();
    // A command offered while busy must be dropped, not queued.
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 6'd1; cmd_b = 6'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({res_valid, cmd_ready, res_c, res_f, res_err} !== {1'b1, 1'b0, 6'd62, 3'b100, 1'b0}) bad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold bad_cycles got %0d exp 0", bad); end
    checks++;
    if ({alu_op, alu_a, alu_b} !== {3'd1, 6'd3, 6'd5}) begin
      errors++; $display("FAIL stall_alu op=%0d a=%0d b=%0d exp 1 3 5", alu_op, alu_a, alu_b);
    end
    release_res();
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_release vld/rdy got %b%b exp 01", res_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, results;
    accepts = 0; results = 0;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 6'd12; cmd_b = 6'd10; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) accepts++;
      step();
      if (res_valid) begin
        results++;
        checks++;
        if (res_c !== 6'd8) begin errors++; $display("FAIL b2b_and_res got %0d exp 8", res_c); end
      end
    end
    cmd_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if (accepts !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", accepts); end
    checks++;
    if (results !== 2) begin errors++; $display("FAIL b2b_results got %0d exp 2", results); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    send(3'd0, 6'd7, 6'd7, 1'b0);
    step();  // now in WAIT
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, res_valid, res_err, res_c, res_f, alu_op, alu_a, alu_b} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, 3'b0, 3'b0, {W{1'b0}}, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid rdy=%b vld=%b err=%b c=%0d f=%b op=%0d a=%0d b=%0d exp rdy=1 rest 0",
               cmd_ready, res_valid, res_err, res_c, res_f, alu_op, alu_a, alu_b);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (res_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_result vld_cycles got %0d exp 0", seen); end
  endtask

  task automatic test_chain();
    logic [W-1:0] exp_a, exp_c;
`ifdef ALU_ISSUE_CHAIN_EN
    exp_a = 6'd5; exp_c = 6'd9;
`else
    exp_a = 6'd1; exp_c = 6'd5;
`endif
    send(3'd0, 6'd2, 6'd3, 1'b0);
    step(); step();
    checks++;
    if (res_c !== 6'd5) begin errors++; $display("FAIL chain_first got %0d exp 5", res_c); end
    release_res();
    send(3'd0, 6'd1, 6'd4, 1'b1);
    checks++;
    if (alu_a !== exp_a) begin errors++; $display("FAIL chain_alu_a got %0d exp %0d", alu_a, exp_a); end
    step(); step();
    checks++;
    if (res_c !== exp_c) begin errors++; $display("FAIL chain_second got %0d exp %0d", res_c, exp_c); end
    release_res();
  endtask

  initial begin
    test_reset();
    test_idle_res_ready();
    test_add_overflow();
    test_sub_and_ovf();
    test_unsupported();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter WIDTH, default 6, operand/result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  3  operation code.
REQ-007 cmd_a  input  WIDTH  operand A.
REQ-008 cmd_b  input  WIDTH  operand B.
REQ-009 cmd_chain  input  1  use the previous result as operand A.
REQ-010 alu_op  output  3  opcode driven to the registered ALU.
REQ-011 alu_a  output  WIDTH  operand A driven to the ALU.
REQ-012 alu_b  output  WIDTH  operand B driven to the ALU.
REQ-013 alu_c  input  WIDTH  ALU result.
REQ-014 alu_f  input  3  ALU flags: [0] zero, [1] overflow, [2] carry/borrow.
REQ-015 res_valid  output  1  result present.
REQ-016 res_ready  input  1  consumer accepts the result.
REQ-017 res_c  output  WIDTH  captured result.
REQ-018 res_f  output  3  captured flags.
REQ-019 res_err  output  1  command carried an unsupported opcode.

Function
REQ-020 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 XOR; 110 and 111 are unsupported.
REQ-021 The FSM states shall be IDLE, ISSUE, WAIT and DONE.
REQ-022 cmd_ready shall be 1 only in IDLE; a command is accepted on an edge with cmd_valid and cmd_ready both 1.
REQ-023 On accept of a supported opcode: register alu_op/alu_a/alu_b from the command, then IDLE->ISSUE.
REQ-024 ISSUE->WAIT unconditionally; the ALU samples alu_* on this edge; alu_* are held stable through ISSUE and WAIT.
REQ-025 WAIT->DONE: capture alu_c into res_c and alu_f into res_f; res_err=0; res_valid=1.
REQ-026 Latency from the accept edge to res_valid high shall be exactly 3 cycles; there is no earlier visibility of the result.
REQ-027 On accept of an unsupported opcode: no ALU issue (alu_* unchanged); IDLE->DONE; res_c=0, res_f=0, res_err=1.
REQ-028 DONE: res_valid, res_c, res_f and res_err are held until an edge with res_ready=1, then DONE->IDLE and res_valid=0; cmd_ready=1 on the following cycle.
REQ-029 res_ready while res_valid=0 shall be ignored; cmd_valid outside IDLE shall be ignored and not queued.
REQ-030 A command held valid continuously shall be accepted once per transaction; throughput is 1 command per 4 cycles at best.
REQ-031 The internal last-result register shall be updated with res_c on every DONE entry from WAIT, and shall not be updated on error entry.

Reset
REQ-032 rst shall force, immediately and in any state including mid-transaction: state IDLE, cmd_ready 1, alu_op 0, alu_a 0, alu_b 0, res_valid 0, res_c 0, res_f 0, res_err 0, last-result 0.
REQ-033 A transaction in flight at reset shall be discarded with no result produced.

Configuration
REQ-034 Macro ALU_ISSUE_CHAIN_EN defined: on accept with cmd_chain=1, alu_a shall be the last-result register (0 after reset) instead of cmd_a.
REQ-035 Macro ALU_ISSUE_CHAIN_EN undefined: cmd_chain is ignored, alu_a is always cmd_a, and no last-result register is built.

Verification
REQ-036 ADD a=63 b=1 -> 3 cycles after accept: res_c=0, res_f=3'b101, res_err=0.
REQ-037 SUB a=3 b=5 -> res_c=62, res_f=3'b100; ADD a=31 b=1 -> res_c=32, res_f=3'b010.
REQ-038 Opcode 111 a=9 b=9 -> res_valid 1 cycle after accept, res_c=0, res_f=0, res_err=1, alu_* unchanged.
REQ-039 res_ready held 0 for 5 cycles in DONE -> outputs stable and cmd_ready=0 throughout; res_ready=1 -> IDLE, cmd_ready=1 next cycle.
REQ-040 rst asserted in WAIT -> all outputs at reset values immediately; no res_valid afterwards.
REQ-041 With ALU_ISSUE_CHAIN_EN: ADD 2+3 then ADD chain b=4 -> second res_c=9; without the macro the same stimulus with cmd_a=1 -> second res_c=5.
